// File: rtl/issue_ctrl.sv
// Issue/dispatch controller: classifies fetched words into ALU/LSB/BRU, allocates ROB tags in order,
// and dispatches with a valid/ready handshake. Optional stats counters under `ISSUE_STATS_EN.
module issue_ctrl #(
  parameter int TAG_W     = 4,
  parameter int ROB_DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inst_valid,
  input  logic [31:0]      inst,
  output logic             inst_ready,
  output logic [31:0]      disp_inst,
  output logic [TAG_W-1:0] disp_tag,
  output logic             alu_valid,
  input  logic             alu_ready,
  output logic             lsb_valid,
  input  logic             lsb_ready,
  output logic             bru_valid,
  input  logic             bru_ready,
  input  logic             commit_valid,
  input  logic             flush,
  output logic             rob_full,
  output logic             illegal,
  output logic [31:0]      stall_cycles,
  output logic [31:0]      issued_count
);

  typedef enum logic {IDLE, HOLD} state_t;
  typedef enum logic [1:0] {C_ALU, C_LSB, C_BRU, C_ILL} cls_t;

  localparam logic [TAG_W:0]   FULL_CNT = (TAG_W+1)'(ROB_DEPTH);
  localparam logic [TAG_W-1:0] LAST_TAG = TAG_W'(ROB_DEPTH - 1);

  state_t           state, next_state;
  cls_t             dec_cls, held_cls;
  logic             is_nop, accept, xfer, commit_ok;
  logic [31:0]      held_inst;
  logic [TAG_W-1:0] head, tail;
  logic [TAG_W:0]   count;
  logic             illegal_q;

  always_comb begin
    dec_cls = C_ILL;
    case (inst[6:0])
      7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: dec_cls = C_ALU;
      7'b0000011, 7'b0100011:                         dec_cls = C_LSB;
      7'b1100011, 7'b1101111, 7'b1100111:             dec_cls = C_BRU;
      default:                                        dec_cls = C_ILL;
    endcase
  end

  assign is_nop    = (inst == 32'h0000_0013);
  assign rob_full  = (count == FULL_CNT);
  assign commit_ok = commit_valid && (count != '0);
  assign disp_inst = held_inst;
  assign disp_tag  = tail;
  assign illegal   = illegal_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Valids and inst_ready are also masked by rst so nothing handshakes during reset.
  always_comb begin
    next_state = state;
    inst_ready = 1'b0;
    alu_valid  = 1'b0;
    lsb_valid  = 1'b0;
    bru_valid  = 1'b0;
    accept     = 1'b0;
    xfer       = 1'b0;
    case (state)
      IDLE: begin
        inst_ready = !flush && !rst;
        accept     = inst_valid && inst_ready;
        if (accept && dec_cls != C_ILL && !is_nop) next_state = HOLD;
      end
      HOLD: begin
        alu_valid = (held_cls == C_ALU) && !rob_full && !rst;
        lsb_valid = (held_cls == C_LSB) && !rob_full && !rst;
        bru_valid = (held_cls == C_BRU) && !rob_full && !rst;
        xfer = !flush && ((alu_valid && alu_ready) || (lsb_valid && lsb_ready) ||
                          (bru_valid && bru_ready));
        if (xfer) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    if (flush) next_state = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      held_inst <= '0;
      held_cls  <= C_ALU;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      illegal_q <= 1'b0;
    end else if (flush) begin
      held_inst <= '0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= accept && (dec_cls == C_ILL);
      if (accept && dec_cls != C_ILL && !is_nop) begin
        held_inst <= inst;
        held_cls  <= dec_cls;
      end
      if (xfer)      tail <= (tail == LAST_TAG) ? '0 : tail + 1'b1;
      if (commit_ok) head <= (head == LAST_TAG) ? '0 : head + 1'b1;
      case ({xfer, commit_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef ISSUE_STATS_EN
  logic [31:0] stall_q, issued_q;

  // Counters survive flush; only rst clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q  <= '0;
      issued_q <= '0;
    end else begin
      if (state == HOLD && !xfer && stall_q != 32'hFFFF_FFFF) stall_q <= stall_q + 1'b1;
      if (xfer && issued_q != 32'hFFFF_FFFF)                  issued_q <= issued_q + 1'b1;
    end
  end

  assign stall_cycles = stall_q;
  assign issued_count = issued_q;
`else
  assign stall_cycles = '0;
  assign issued_count = '0;
`endif

endmodule
